// File: rtl/stepper_phase_sequencer.sv
// ---------------------------------------------------------------------------
// stepper_phase_sequencer
//
// Purpose:
//   Sequences a 4-coil stepper drive through an 8-entry phase table. It
//   supports full-step (+/-2) and half-step (+/-1) motion, direction control,
//   free-run at one of two prescaled rates, single-step on a rising edge of
//   the step input, hold (coils energised, no motion) and de-energise.
//
// Ports (8-in / 8-out pin interface):
//   io_in[0]   clock
//   io_in[1]   reset, synchronous, active-high
//   io_in[2]   enable   (0 de-energises all coils)
//   io_in[3]   dir      (1 forward, 0 reverse)
//   io_in[4]   half     (1 half-step, 0 full-step)
//   io_in[5]   run      (level, free-run while high)
//   io_in[6]   step     (rising edge requests one step while holding)
//   io_in[7]   rate_sel (1 DIV_FAST, 0 DIV_SLOW)
//   io_out[3:0] coil drive D,C,B,A (bit0 = A), active-high
//   io_out[4]   moving      (high while free-running)
//   io_out[5]   step_strobe (one-cycle pulse after each phase advance)
//   io_out[6]   index       (phase 0 and coils energised)
//   io_out[7]   dir_last    (direction of the most recent advance)
// ---------------------------------------------------------------------------
module stepper_phase_sequencer #(
  parameter int CNT_W    = 16,
  parameter int DIV_FAST = 4,
  parameter int DIV_SLOW = 16
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Pin breakout
  logic clk_s;
  logic rst_s;
  logic enable_s;
  logic dir_s;
  logic half_s;
  logic run_s;
  logic step_s;
  logic rate_sel_s;

  assign clk_s      = io_in[0];
  assign rst_s      = io_in[1];
  assign enable_s   = io_in[2];
  assign dir_s      = io_in[3];
  assign half_s     = io_in[4];
  assign run_s      = io_in[5];
  assign step_s     = io_in[6];
  assign rate_sel_s = io_in[7];

  // Sequential state
  state_t             state_r;
  logic [2:0]         phase_r;
  logic [CNT_W-1:0]   presc_r;
  logic               step_d_r;
  logic [3:0]         coil_r;
  logic               moving_r;
  logic               strobe_r;
  logic               index_r;
  logic               dir_last_r;

  // Next-state decisions
  state_t             state_nxt_s;
  logic [2:0]         phase_nxt_s;
  logic [CNT_W-1:0]   presc_nxt_s;
  logic               adv_s;
  logic               step_edge_s;
  logic [CNT_W-1:0]   period_m1_s;

  // Phase -> coil pattern: even phases drive one coil, odd phases drive the
  // two neighbouring coils (DA wraps coil D back to coil A).
  function automatic logic [3:0] coil_decode(input logic [2:0] ph);
    logic [3:0] c;
    case (ph)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b1100;
      3'd6:    c = 4'b1000;
      3'd7:    c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Phase advance; the 3-bit result wraps mod 8, so full-steps keep parity.
  function automatic logic [2:0] step_phase(input logic [2:0] ph,
                                            input logic       fwd,
                                            input logic       hlf);
    logic [2:0] delta;
    logic [2:0] res;
    if (hlf) begin
      delta = 3'd1;
    end else begin
      delta = 3'd2;
    end
    if (fwd) begin
      res = ph + delta;
    end else begin
      res = ph - delta;
    end
    return res;
  endfunction

  assign step_edge_s = step_s & ~step_d_r;

  // Terminal count for the selected rate, re-evaluated every cycle so a rate
  // change mid-count takes effect immediately via the >= compare below.
  always_comb begin
    if (rate_sel_s) begin
      period_m1_s = CNT_W'(DIV_FAST - 1);
    end else begin
      period_m1_s = CNT_W'(DIV_SLOW - 1);
    end
  end

  // Next state, prescaler and advance decision; enable=0 overrides all else.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = {CNT_W{1'b0}};
    adv_s       = 1'b0;
    if (!enable_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_HOLD;
        end
        ST_HOLD: begin
          // run wins over a coincident step edge; the edge is dropped
          if (run_s) begin
            state_nxt_s = ST_RUN;
          end else if (step_edge_s) begin
            adv_s = 1'b1;
          end else begin
            adv_s = 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_s) begin
            state_nxt_s = ST_HOLD;
          end else if (presc_r >= period_m1_s) begin
            adv_s = 1'b1;
          end else begin
            presc_nxt_s = presc_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    if (adv_s) begin
      phase_nxt_s = step_phase(phase_r, dir_s, half_s);
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // FSM state and registered outputs; outputs are computed from the values
  // being loaded so coils change on the same edge as the phase.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_r    <= ST_IDLE;
      phase_r    <= 3'd0;
      presc_r    <= {CNT_W{1'b0}};
      step_d_r   <= 1'b0;
      coil_r     <= 4'b0000;
      moving_r   <= 1'b0;
      strobe_r   <= 1'b0;
      index_r    <= 1'b0;
      dir_last_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      phase_r  <= phase_nxt_s;
      presc_r  <= presc_nxt_s;
      step_d_r <= step_s;
      if (state_nxt_s == ST_IDLE) begin
        coil_r <= 4'b0000;
      end else begin
        coil_r <= coil_decode(phase_nxt_s);
      end
      moving_r <= (state_nxt_s == ST_RUN);
      strobe_r <= adv_s;
      index_r  <= (state_nxt_s != ST_IDLE) && (phase_nxt_s == 3'd0);
      if (adv_s) begin
        dir_last_r <= dir_s;
      end else begin
        dir_last_r <= dir_last_r;
      end
    end
  end

  assign io_out = {dir_last_r, index_r, strobe_r, moving_r, coil_r};

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stepper_phase_sequencer
//
// Self-checking bench: directed scenarios with hand-derived expectations,
// followed by randomized stimulus compared every cycle against a behavioural
// model of the sequencer (mode, phase number, clocks elapsed since the last
// advance).
// ---------------------------------------------------------------------------
module tb_stepper_phase_sequencer;

  localparam int DIV_FAST = 4;
  localparam int DIV_SLOW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       half;
  logic       run;
  logic       step;
  logic       rate;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int errors = 0;
  int checks = 0;

  // behavioural model: mode 0 = off, 1 = holding, 2 = running
  int   m_mode;
  int   m_phase;
  int   m_elapsed;
  bit   m_step_prev;
  bit   m_strobe;
  bit   m_dir_last;

  assign io_in = {rate, step, run, half, dir, en, rst, clk};

  stepper_phase_sequencer #(
    .CNT_W(16),
    .DIV_FAST(DIV_FAST),
    .DIV_SLOW(DIV_SLOW)
  ) dut (
    .io_in(io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Coil pattern from the phase number: even phase -> single coil phase/2,
  // odd phase -> the two coils either side (coil index wraps mod 4).
  function automatic logic [3:0] model_coils(input int ph);
    logic [3:0] c;
    c = 4'b0000;
    if (ph % 2 == 0) begin
      c[ph / 2] = 1'b1;
    end else begin
      c[(ph - 1) / 2]       = 1'b1;
      c[((ph + 1) / 2) % 4] = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [7:0] model_out();
    logic [3:0] c;
    c = (m_mode == 0) ? 4'b0000 : model_coils(m_phase);
    return {m_dir_last, (m_mode != 0 && m_phase == 0), m_strobe, (m_mode == 2), c};
  endfunction

  task automatic model_step();
    bit adv;
    bit rise;
    int period;
    adv = 1'b0;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_elapsed = 0;
      m_step_prev = 1'b0; m_strobe = 1'b0; m_dir_last = 1'b0;
    end else begin
      rise   = step && !m_step_prev;
      period = rate ? DIV_FAST : DIV_SLOW;
      if (!en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (run) begin
          m_mode = 2;
          m_elapsed = 0;
        end else if (rise) begin
          adv = 1'b1;
        end
      end else begin
        if (!run) begin
          m_mode = 1;
        end else begin
          m_elapsed++;
          if (m_elapsed >= period) begin
            adv = 1'b1;
            m_elapsed = 0;
          end
        end
      end
      if (adv) begin
        m_phase    = (m_phase + (dir ? 1 : -1) * (half ? 1 : 2) + 8) % 8;
        m_dir_last = dir;
      end
      m_strobe    = adv;
      m_step_prev = step;
    end
  endtask

  // one clock: inputs already set, advance model, compare whole output byte
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_val("model", io_out, model_out());
  endtask

  logic [3:0] t2_exp [5];
  logic [3:0] t3_exp [4];
  int         n;

  initial begin
    t2_exp[0] = 4'b0011; t2_exp[1] = 4'b0010; t2_exp[2] = 4'b0110;
    t2_exp[3] = 4'b0100; t2_exp[4] = 4'b1100;
    t3_exp[0] = 4'b1000; t3_exp[1] = 4'b0100; t3_exp[2] = 4'b0010; t3_exp[3] = 4'b0001;

    rst = 1'b1; en = 1'b0; dir = 1'b0; half = 1'b0;
    run = 1'b0; step = 1'b0; rate = 1'b0;

    // 1: reset, enable, disable, re-enable
    cyc();
    check_val("reset", io_out, 8'h00);
    rst = 1'b0; en = 1'b1;
    cyc();
    check_val("t1_hold", io_out, 8'b0100_0001);
    en = 1'b0;
    cyc();
    check_val("t1_idle_coils", {4'b0000, io_out[3:0]}, 8'h00);
    en = 1'b1;
    cyc();
    check_val("t1_reenable", {4'b0000, io_out[3:0]}, 8'h01);

    // 2: half-step forward single steps
    half = 1'b1; dir = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step = 1'b1;
      cyc();
      check_val("t2_coils", {4'b0000, io_out[3:0]}, {4'b0000, t2_exp[k]});
      check_val("t2_strobe", {7'd0, io_out[5]}, 8'd1);
      cyc();
      check_val("t2_strobe_off", {7'd0, io_out[5]}, 8'd0);
      step = 1'b0;
      cyc();
      cyc();
    end
    n = 0;
    step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n += int'(io_out[5]);
    end
    check_val("t2_held_step", 8'(n), 8'd1);
    step = 1'b0;
    cyc();

    // 3: full-step reverse from phase 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    half = 1'b0; dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      cyc();
      check_val("t3_coils", {4'b0000, io_out[3:0]}, {4'b0000, t3_exp[k]});
      step = 1'b0;
      cyc();
    end
    check_val("t3_index_dirlast", {6'd0, io_out[7:6]}, 8'b01);

    // 4: free-run fast, then switch to slow mid-count
    half = 1'b1; dir = 1'b1; rate = 1'b1; run = 1'b1;
    cyc();
    check_val("t4_entry", {6'd0, io_out[5:4]}, 8'b01);
    for (int i = 1; i <= 14; i++) begin
      cyc();
      check_val("t4_fast_strobe", {7'd0, io_out[5]}, {7'd0, (i % 4 == 0 && i <= 12)});
      check_val("t4_moving", {7'd0, io_out[4]}, 8'd1);
    end
    rate = 1'b0;
    for (int i = 15; i <= 30; i++) begin
      cyc();
      check_val("t4_slow_strobe", {7'd0, io_out[5]}, {7'd0, (i == 28)});
    end

    // 5: reset while running, run and enable still high
    cyc();
    rst = 1'b1;
    cyc();
    check_val("t5_reset_run", io_out, 8'h00);
    rst = 1'b0;
    cyc();
    check_val("t5_via_hold", io_out, 8'b0100_0001);
    cyc();
    check_val("t5_run_again", {6'd0, io_out[5:4]}, 8'b01);

    // 6: run and step rising together, then enable dropped at terminal count
    run = 1'b0;
    cyc();
    cyc();
    run = 1'b1; step = 1'b1; rate = 1'b1;
    cyc();
    check_val("t6_run_wins", io_out, 8'b0101_0001);
    step = 1'b0;
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    check_val("t6_drop_at_tc", io_out, 8'h00);

    // randomized stimulus against the model
    en = 1'b1; run = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 29) == 0) rate = ~rate;
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      if ($urandom_range(0, 3) == 0) half = ~half;
      if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_phase_sequencer.md
Name: stepper_phase_sequencer

Overview:
- Controller that sequences a 4-coil stepper drive, a generalisation of the existing 2-flip-flop 4-phase Johnson sequencer.
- Supports full-step and half-step sequences, direction control, free-run at two programmable rates, single-step on request, and hold/de-energise.
- Sits as a standalone user module behind the standard 8-in/8-out pin interface.

Parameters:
- CNT_W, 16: prescaler counter width in bits.
- DIV_FAST, 4: clocks per step in RUN when rate_sel=1. Legal range 1..2^CNT_W-1.
- DIV_SLOW, 16: clocks per step in RUN when rate_sel=0. Legal range 1..2^CNT_W-1.

Ports:
- io_in[0], input, 1: clock.
- io_in[1], input, 1: reset, synchronous, active-high.
- io_in[2], input, 1: enable. 0 de-energises all coils.
- io_in[3], input, 1: dir. 1 = forward (+), 0 = reverse (−).
- io_in[4], input, 1: half. 1 = half-step (±1), 0 = full-step (±2).
- io_in[5], input, 1: run. Level; free-run while high.
- io_in[6], input, 1: step. Rising edge requests one step.
- io_in[7], input, 1: rate_sel. 1 = DIV_FAST, 0 = DIV_SLOW.
- io_out[3:0], output, 4: coil drive D,C,B,A (bit0 = A), active-high.
- io_out[4], output, 1: moving. High while state = RUN.
- io_out[5], output, 1: step_strobe. One-cycle pulse after each phase advance.
- io_out[6], output, 1: index. High when phase = 0 and state ≠ IDLE.
- io_out[7], output, 1: dir_last. Direction used on the most recent advance.

Behaviour:
- Reset (synchronous, highest priority):
  - state = IDLE, phase = 0, prescaler = 0, step_d = 0.
  - All io_out = 0.
- Phase register, 3 bits, mod 8. Coil decode:
  - 0:A, 1:AB, 2:B, 3:BC, 4:C, 5:CD, 6:D, 7:DA.
  - Coils are all 0 in IDLE; otherwise the coils reflect the current phase.
- Advance rule:
  - phase ← phase ± (half ? 1 : 2) mod 8, using dir and half sampled at the advancing edge.
  - Full-step preserves parity: even phases give wave drive, odd phases give two-phase drive.
  - Wrap-around 7→0 / 0→7 (half-step) and 6→0 / 0→6 (full-step from even) is natural mod 8.
- Step edge detect: step_d registers io_in[6] every cycle. edge = io_in[6] & ~step_d.
- States:
  - IDLE: entered from any state when enable=0, evaluated before all other transitions. Phase is retained.
    - enable=1 → HOLD.
  - HOLD: coils energised, no motion.
    - enable=0 → IDLE.
    - run=1 → RUN, prescaler ← 0.
    - else if edge → advance at this edge, stay in HOLD.
  - RUN:
    - enable=0 → IDLE.
    - run=0 → HOLD, with no advance on that edge.
    - else prescaler increments each clock. When prescaler ≥ period−1: advance, prescaler ← 0.
    - period is re-evaluated every cycle from the current rate_sel. The ≥ compare makes a rate change mid-count complete without rollover.
    - Step edges are ignored in RUN.
- Latency:
  - First RUN advance occurs exactly `period` clocks after the edge that enters RUN.
  - HOLD single-step: phase/coils change at the edge that detects the step edge.
- step_strobe:
  - Registered; high for exactly the one cycle following each advance.
  - Forced 0 in the cycle after reset, and in the cycle after entering IDLE.
- dir_last updates only on an advance.
- Simultaneous events:
  - run and edge together in HOLD → RUN wins and the edge is dropped.
  - enable falling in the same cycle as an advance condition → IDLE, no advance.
- Reset mid-RUN: returns to phase 0, coils off, moving = 0 on the next clock.

Test Plan:
1. Reset, then enable=1, run=0 → io_out[3:0] = 0001, index = 1, moving = 0. Then enable=0 → coils 0000 and phase retained (re-enable shows 0001 again).
2. HOLD, half=1, dir=1, five step rising edges (each held ≥2 clocks) → coils 0011, 0010, 0110, 0100, 1100. One step_strobe per edge. A step held high for 10 clocks produces only one advance.
3. HOLD, half=0, dir=0, phase 0, four edges → coils 1000, 0100, 0010, 0001. index pulses on return to phase 0. dir_last = 0.
4. run=1, rate_sel=1, half=1, dir=1 → advances at exactly 4, 8, 12, … clocks after entry. Switch rate_sel=0 mid-count → next advance comes 16 clocks after the previous one. moving = 1 throughout.
5. RUN with reset asserted mid-count → next cycle all outputs 0 and phase = 0. With run still high after reset, no motion until enable passes through HOLD.
6. HOLD with run and step rising on the same edge → enters RUN with no immediate advance. In RUN, enable dropped at the terminal count → IDLE, coils 0000, no step_strobe.
